ram_dp: RTL and testbench

Parametrised dual-port data/instruction memory for the B microprocessor, replacing the single-port tri-state RAM. Port A is a registered read/write data port with byte enables; port B is a registered read-only fetch port. After every reset, a built-in sequencer rewrites the whole array to a defined pattern, and both ports hold off requests until it finishes. All accesses use a request/valid handshake with fixed one-cycle read latency.

---
 rtl/ram_dp.sv | 142 ++++++++++++++
 tb/tb_ram_dp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp.sv
// rtl/ram_dp.sv - dual-port word RAM with byte-enabled port A, read-only port B and reset-time fill
module ram_dp #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 8,
    parameter int MEMDEPTH  = 256,
    parameter int INIT_MODE = 0,
    localparam int NBYTES   = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    input  logic [NBYTES-1:0] a_be,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic [AWIDTH-1:0] b_addr,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata
);
    // Index width covers only the implemented words; range checks use the full address.
    localparam int IW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
    localparam logic [AWIDTH:0] DEPTH_A  = (AWIDTH + 1)'(MEMDEPTH);
    localparam logic [IW-1:0]   LAST_PTR = IW'(MEMDEPTH - 1);

    typedef enum logic {ST_FILL, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              a_err_q, a_err_d;
    logic [DWIDTH-1:0] a_rdata_q, a_rdata_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DWIDTH-1:0] b_rdata_q, b_rdata_d;

    logic [DWIDTH-1:0] mem [MEMDEPTH];
    logic              mem_we;
    logic [IW-1:0]     mem_widx;
    logic [DWIDTH-1:0] mem_wdata;
    logic [NBYTES-1:0] mem_wbe;

    logic              a_in_range, b_in_range;
    logic [IW-1:0]     a_idx, b_idx;
    logic [DWIDTH-1:0] fill_val;

    assign a_in_range = ({1'b0, a_addr} < DEPTH_A);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_A);
    assign a_idx      = a_addr[IW-1:0];
    assign b_idx      = b_addr[IW-1:0];
    assign fill_val   = (INIT_MODE == 0) ? DWIDTH'(ptr_q) : '0;

    assign init_busy = (state_q == ST_FILL);
    assign a_ready   = !init_busy;
    assign b_ready   = !init_busy;
    assign a_rvalid  = a_rvalid_q;
    assign a_err     = a_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rvalid  = b_rvalid_q;
    assign b_rdata   = b_rdata_q;

    // Next-state: fill sequencing, port accept decode and the single memory write port.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_rvalid_d = 1'b0;
        a_err_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rvalid_d = 1'b0;
        b_rdata_d  = b_rdata_q;
        mem_we     = 1'b0;
        mem_widx   = a_idx;
        mem_wdata  = a_wdata;
        mem_wbe    = a_be;
        case (state_q)
            ST_FILL: begin
                // Gate on reset so a held reset never disturbs the array.
                mem_we    = reset;
                mem_widx  = ptr_q;
                mem_wdata = fill_val;
                mem_wbe   = '1;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Reads sample the array before this edge's write lands: read-before-write.
                if (a_req && a_we) begin
                    mem_we  = a_in_range;
                    a_err_d = !a_in_range;
                end else if (a_req) begin
                    a_rvalid_d = 1'b1;
                    a_err_d    = !a_in_range;
                    a_rdata_d  = a_in_range ? mem[a_idx] : '0;
                end
                if (b_req) begin
                    b_rvalid_d = 1'b1;
                    b_rdata_d  = b_in_range ? mem[b_idx] : '0;
                end
            end
        endcase
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_FILL;
            ptr_q      <= '0;
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_rvalid_q <= a_rvalid_d;
            a_err_q    <= a_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Storage array: byte-masked write, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_dp.sv
// tb/tb_ram_dp.sv - self-checking bench for ram_dp, both fill patterns side by side
module tb_ram_dp;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_wdata;
    logic [1:0]  a_be;

    logic        busy_o [2];
    logic        a_ready_o [2];
    logic        a_rvalid_o [2];
    logic        a_err_o [2];
    logic [15:0] a_rdata_o [2];
    logic        b_ready_o [2];
    logic        b_rvalid_o [2];
    logic [15:0] b_rdata_o [2];

    int checks = 0;
    int errors = 0;

    ram_dp #(.DWIDTH(16), .AWIDTH(5), .MEMDEPTH(DEPTH), .INIT_MODE(0)) u_m0 (
        .clk(clk), .reset(rst_n), .init_busy(busy_o[0]),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ready(a_ready_o[0]), .a_rvalid(a_rvalid_o[0]), .a_rdata(a_rdata_o[0]), .a_err(a_err_o[0]),
        .b_req(b_req), .b_addr(b_addr),
        .b_ready(b_ready_o[0]), .b_rvalid(b_rvalid_o[0]), .b_rdata(b_rdata_o[0])
    );

    ram_dp #(.DWIDTH(16), .AWIDTH(5), .MEMDEPTH(DEPTH), .INIT_MODE(1)) u_m1 (
        .clk(clk), .reset(rst_n), .init_busy(busy_o[1]),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ready(a_ready_o[1]), .a_rvalid(a_rvalid_o[1]), .a_rdata(a_rdata_o[1]), .a_err(a_err_o[1]),
        .b_req(b_req), .b_addr(b_addr),
        .b_ready(b_ready_o[1]), .b_rvalid(b_rvalid_o[1]), .b_rdata(b_rdata_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fill counter, word arrays and expected registered outputs per instance.
    logic [15:0] mmem [2][DEPTH];
    logic        mbusy [2];
    int          mfill [2];
    logic        m_arv [2];
    logic        m_aerr [2];
    logic [15:0] m_ard [2];
    logic        m_brv [2];
    logic [15:0] m_brd [2];

    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                mbusy[m]  = 1'b1;
                mfill[m]  = 0;
                m_arv[m]  = 1'b0;
                m_aerr[m] = 1'b0;
                m_ard[m]  = 16'h0;
                m_brv[m]  = 1'b0;
                m_brd[m]  = 16'h0;
            end else if (mbusy[m]) begin
                mmem[m][mfill[m]] = (m == 0) ? 16'(mfill[m]) : 16'h0;
                mfill[m]++;
                if (mfill[m] == DEPTH) mbusy[m] = 1'b0;
                m_arv[m]  = 1'b0;
                m_aerr[m] = 1'b0;
                m_brv[m]  = 1'b0;
            end else begin
                m_arv[m]  = a_req && !a_we;
                m_aerr[m] = a_req && (int'(a_addr) >= DEPTH);
                if (a_req && !a_we)
                    m_ard[m] = (int'(a_addr) < DEPTH) ? mmem[m][a_addr[3:0]] : 16'h0;
                m_brv[m] = b_req;
                if (b_req)
                    m_brd[m] = (int'(b_addr) < DEPTH) ? mmem[m][b_addr[3:0]] : 16'h0;
                if (a_req && a_we && int'(a_addr) < DEPTH) begin
                    logic [15:0] mask;
                    mask = {{8{a_be[1]}}, {8{a_be[0]}}};
                    mmem[m][a_addr[3:0]] = (mmem[m][a_addr[3:0]] & ~mask) | (a_wdata & mask);
                end
            end
        end
    end

    // Every cycle, both instances against the model.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d init_busy", m), 32'(busy_o[m]), 32'(mbusy[m]));
            chk($sformatf("m%0d a_ready", m), 32'(a_ready_o[m]), 32'(!mbusy[m]));
            chk($sformatf("m%0d b_ready", m), 32'(b_ready_o[m]), 32'(!mbusy[m]));
            chk($sformatf("m%0d a_rvalid", m), 32'(a_rvalid_o[m]), 32'(m_arv[m]));
            chk($sformatf("m%0d a_err", m), 32'(a_err_o[m]), 32'(m_aerr[m]));
            chk($sformatf("m%0d a_rdata", m), 32'(a_rdata_o[m]), 32'(m_ard[m]));
            chk($sformatf("m%0d b_rvalid", m), 32'(b_rvalid_o[m]), 32'(m_brv[m]));
            chk($sformatf("m%0d b_rdata", m), 32'(b_rdata_o[m]), 32'(m_brd[m]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [4:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    endtask

    task automatic set_b(input logic req, input logic [4:0] addr);
        b_req = req; b_addr = addr;
    endtask

    task automatic count_fill(input string name);
        int n;
        n = 0;
        while (busy_o[0] && n < 100) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0);
        repeat (3) step();
        chk("reset init_busy", 32'(busy_o[0]), 32'd1);
        chk("reset a_ready", 32'(a_ready_o[0]), 32'd0);
        chk("reset b_rdata", 32'(b_rdata_o[0]), 32'd0);

        // Reset and fill, then stream B reads over the whole array.
        rst_n = 1'b1;
        count_fill("fill cycles");
        for (int i = 0; i < DEPTH; i++) begin
            set_b(1, 5'(i));
            step();
            chk($sformatf("fill b_rvalid %0d", i), 32'(b_rvalid_o[0]), 32'd1);
            chk($sformatf("fill b_rdata %0d", i), 32'(b_rdata_o[0]), 32'(i));
        end
        set_b(0, 0);

        // Byte-enabled writes on port A.
        set_a(1, 1, 3, 16'hBEEF, 2'b11); step();
        set_a(1, 1, 3, 16'h1200, 2'b10); step();
        chk("write a_rvalid", 32'(a_rvalid_o[0]), 32'd0);
        set_a(1, 0, 3, 16'h0, 2'b00); step();
        chk("bytewr a_rvalid", 32'(a_rvalid_o[0]), 32'd1);
        chk("bytewr a_rdata m0", 32'(a_rdata_o[0]), 32'h12EF);
        chk("bytewr a_rdata m1", 32'(a_rdata_o[1]), 32'h12EF);

        // Collision: read-before-write.
        set_a(1, 1, 5, 16'hAAAA, 2'b11);
        set_b(1, 5);
        step();
        chk("collide b_rdata m0", 32'(b_rdata_o[0]), 32'h0005);
        chk("collide b_rdata m1", 32'(b_rdata_o[1]), 32'h0000);
        set_a(0, 0, 0, 0, 0);
        step();
        chk("after collide b_rdata", 32'(b_rdata_o[0]), 32'hAAAA);
        set_b(0, 0);

        // Out-of-range accesses.
        set_a(1, 1, 20, 16'h1234, 2'b11); step();
        chk("oor wr a_err", 32'(a_err_o[0]), 32'd1);
        chk("oor wr a_rvalid", 32'(a_rvalid_o[0]), 32'd0);
        set_a(0, 0, 0, 0, 0); step();
        chk("oor err drops", 32'(a_err_o[0]), 32'd0);
        set_a(1, 0, 20, 0, 0); step();
        chk("oor rd a_rvalid", 32'(a_rvalid_o[0]), 32'd1);
        chk("oor rd a_err", 32'(a_err_o[0]), 32'd1);
        chk("oor rd a_rdata", 32'(a_rdata_o[0]), 32'd0);
        set_a(1, 0, 4, 0, 0);
        set_b(1, 17);
        step();
        chk("oor b_rvalid", 32'(b_rvalid_o[0]), 32'd1);
        chk("oor b_rdata", 32'(b_rdata_o[0]), 32'd0);
        chk("alias addr4 intact", 32'(a_rdata_o[0]), 32'h0004);
        chk("alias a_err clear", 32'(a_err_o[0]), 32'd0);

        // Reset mid-RUN with reads in flight: outputs clear at once, no rvalid afterwards.
        set_a(1, 0, 2, 0, 0);
        set_b(1, 9);
        rst_n = 1'b0;
        #1;
        chk("midrun a_rdata", 32'(a_rdata_o[0]), 32'd0);
        chk("midrun init_busy", 32'(busy_o[0]), 32'd1);
        chk("midrun b_ready", 32'(b_ready_o[0]), 32'd0);
        step();
        chk("midrun a_rvalid", 32'(a_rvalid_o[0]), 32'd0);
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0);
        step();
        rst_n = 1'b1;

        // Reset at fill cycle 7, hold two cycles, restart the fill.
        repeat (7) step();
        chk("midfill busy", 32'(busy_o[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midfill a_ready", 32'(a_ready_o[0]), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        count_fill("refill cycles");

        // Whole-array readback on both ports, both patterns.
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 0, 5'(i), 0, 0);
            set_b(1, 5'(DEPTH - 1 - i));
            step();
            chk($sformatf("final a m0 %0d", i), 32'(a_rdata_o[0]), 32'(i));
            chk($sformatf("final b m0 %0d", i), 32'(b_rdata_o[0]), 32'(DEPTH - 1 - i));
            chk($sformatf("final a m1 %0d", i), 32'(a_rdata_o[1]), 32'd0);
            chk($sformatf("final b m1 %0d", i), 32'(b_rdata_o[1]), 32'd0);
        end
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
